// File: rtl/sorter_pkg.sv
// Shared sorter definitions: width helpers and the result-checker FSM state type.
package sorter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } chk_state_t;

    // Constant-bounded loop so the helper elaborates cleanly in synthesis.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int calc_iw(input int n);
        return (clog2(n) > 1) ? clog2(n) : 1;
    endfunction

    function automatic int calc_cw(input int n);
        return clog2(n + 1);
    endfunction

endpackage

// File: rtl/elem_match_count.sv
// Counts how many DW-bit slices of a packed N-element vector equal a key (combinational).
module elem_match_count
    import sorter_pkg::*;
#(
    parameter int DW = 3,
    parameter int N  = 4,
    localparam int CW = calc_cw(N)
) (
    input  logic [DW-1:0]   i_key,
    input  logic [DW*N-1:0] i_vec,
    output logic [CW-1:0]   o_count
);

    always_comb begin
        o_count = '0;
        for (int k = 0; k < N; k++) begin
            if (i_vec[k*DW +: DW] == i_key) o_count = o_count + CW'(1);
        end
    end

endmodule

// File: rtl/sort_result_checker.sv
// Checks a sorter result for ordering and for being a permutation of its input.
// Optional SORT_CHECK_STATS_EN adds saturating pass/fail counters.
module sort_result_checker
    import sorter_pkg::*;
#(
    parameter int DW         = 3,
    parameter int N          = 4,
    parameter bit DESCENDING = 1'b0,
    localparam int IW = calc_iw(N),
    localparam int CW = calc_cw(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    // Handshake: a pair transfers on a rising edge where in_valid && in_ready;
    // in_ready is high only while idle, and inp/outp are sampled on that edge only.
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW*N-1:0] inp,
    input  logic [DW*N-1:0] outp,
    output logic            res_valid,
    output logic            res_pass,
    output logic            res_order_err,
    output logic            res_perm_err,
    output logic [IW-1:0]   res_first_bad,
    output chk_state_t      dbg_state
`ifdef SORT_CHECK_STATS_EN
    ,
    output logic [15:0]     pass_cnt,
    output logic [15:0]     fail_cnt
`endif
);

    chk_state_t         r_state;
    logic [DW*N-1:0]    r_inp;
    logic [DW*N-1:0]    r_outp;
    logic [IW-1:0]      r_idx;
    logic               r_order_flag;
    logic [IW-1:0]      r_order_idx;
    logic               r_perm_flag;
    logic [IW-1:0]      r_perm_idx;

    logic               w_order_bad;
    logic [IW-1:0]      w_order_idx;
    logic [DW-1:0]      w_key;
    logic [CW-1:0]      w_cnt_in;
    logic [CW-1:0]      w_cnt_out;
    logic               w_mismatch;
    logic               w_perm_next;
    logic [IW-1:0]      w_perm_idx_next;
    logic               w_pass_next;

    // Walk downward so the lowest violating neighbour pair wins.
    always_comb begin
        w_order_bad = 1'b0;
        w_order_idx = '0;
        for (int i = N - 2; i >= 0; i--) begin
            if (DESCENDING ? (outp[i*DW +: DW] < outp[(i+1)*DW +: DW])
                           : (outp[i*DW +: DW] > outp[(i+1)*DW +: DW])) begin
                w_order_bad = 1'b1;
                w_order_idx = IW'(i);
            end
        end
    end

    always_comb begin
        w_key = '0;
        for (int k = 0; k < N; k++) begin
            if (r_idx == IW'(k)) w_key = r_inp[k*DW +: DW];
        end
    end

    elem_match_count #(.DW(DW), .N(N)) u_count_in (
        .i_key   (w_key),
        .i_vec   (r_inp),
        .o_count (w_cnt_in)
    );

    elem_match_count #(.DW(DW), .N(N)) u_count_out (
        .i_key   (w_key),
        .i_vec   (r_outp),
        .o_count (w_cnt_out)
    );

    assign w_mismatch      = (w_cnt_in != w_cnt_out);
    assign w_perm_next     = r_perm_flag | w_mismatch;
    assign w_perm_idx_next = (!r_perm_flag && w_mismatch) ? r_idx : r_perm_idx;
    assign w_pass_next     = !(r_order_flag || w_perm_next);

    assign in_ready  = (r_state == IDLE);
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_inp         <= '0;
            r_outp        <= '0;
            r_idx         <= '0;
            r_order_flag  <= 1'b0;
            r_order_idx   <= '0;
            r_perm_flag   <= 1'b0;
            r_perm_idx    <= '0;
            res_valid     <= 1'b0;
            res_pass      <= 1'b0;
            res_order_err <= 1'b0;
            res_perm_err  <= 1'b0;
            res_first_bad <= '0;
`ifdef SORT_CHECK_STATS_EN
            pass_cnt      <= '0;
            fail_cnt      <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_inp        <= inp;
                        r_outp       <= outp;
                        r_order_flag <= w_order_bad;
                        r_order_idx  <= w_order_idx;
                        r_perm_flag  <= 1'b0;
                        r_perm_idx   <= '0;
                        r_idx        <= '0;
                        r_state      <= SCAN;
                    end
                end
                SCAN: begin
                    r_perm_flag <= w_perm_next;
                    r_perm_idx  <= w_perm_idx_next;
                    if (r_idx == IW'(N - 1)) begin
                        // Verdict registers load here so they are valid throughout REPORT.
                        r_state       <= REPORT;
                        res_valid     <= 1'b1;
                        res_order_err <= r_order_flag;
                        res_perm_err  <= w_perm_next;
                        res_pass      <= w_pass_next;
                        res_first_bad <= r_order_flag ? r_order_idx
                                       : (w_perm_next ? w_perm_idx_next : '0);
`ifdef SORT_CHECK_STATS_EN
                        if (w_pass_next && pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
                        if (!w_pass_next && fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
`endif
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                REPORT: begin
                    res_valid <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_result_checker.sv
// Self-checking bench for sort_result_checker: per-cycle compare against a behavioural model,
// directed test-plan cases, held-valid throughput, descending instance and mid-scan reset.
module tb_sort_result_checker;
    import sorter_pkg::*;

    localparam int DW  = 3;
    localparam int N   = 4;
    localparam int IW  = 2;
    localparam int VW  = DW * N;
    localparam int VDW = 3 + IW;   // {pass, order_err, perm_err, first_bad}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [VW-1:0]   inp = '0;
    logic [VW-1:0]   outp = '0;
    logic            res_valid, res_pass, res_order_err, res_perm_err;
    logic [IW-1:0]   res_first_bad;
    chk_state_t      dbg_state;

    logic            d_in_valid = 1'b0;
    logic            d_in_ready;
    logic [VW-1:0]   d_inp = '0;
    logic [VW-1:0]   d_outp = '0;
    logic            d_res_valid, d_res_pass, d_res_order_err, d_res_perm_err;
    logic [IW-1:0]   d_res_first_bad;
    chk_state_t      d_dbg_state;

`ifdef SORT_CHECK_STATS_EN
    logic [15:0] pass_cnt, fail_cnt, d_pass_cnt, d_fail_cnt;
`endif

    sort_result_checker #(.DW(DW), .N(N), .DESCENDING(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .inp(inp), .outp(outp), .res_valid(res_valid), .res_pass(res_pass),
        .res_order_err(res_order_err), .res_perm_err(res_perm_err),
        .res_first_bad(res_first_bad), .dbg_state(dbg_state)
`ifdef SORT_CHECK_STATS_EN
        , .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
`endif
    );

    sort_result_checker #(.DW(DW), .N(N), .DESCENDING(1'b1)) dut_desc (
        .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .inp(d_inp), .outp(d_outp), .res_valid(d_res_valid), .res_pass(d_res_pass),
        .res_order_err(d_res_order_err), .res_perm_err(d_res_perm_err),
        .res_first_bad(d_res_first_bad), .dbg_state(d_dbg_state)
`ifdef SORT_CHECK_STATS_EN
        , .pass_cnt(d_pass_cnt), .fail_cnt(d_fail_cnt)
`endif
    );

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [VW-1:0] pk(input int e0, input int e1, input int e2, input int e3);
        return {DW'(e3), DW'(e2), DW'(e1), DW'(e0)};
    endfunction

    // Verdict straight from the rules: first bad neighbour pair, then first input key
    // whose multiplicity differs between the two vectors.
    function automatic logic [VDW-1:0] model_check(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                                   input bit desc);
        int av[N];
        int bv[N];
        bit oerr = 1'b0;
        bit perr = 1'b0;
        int oi = 0;
        int pi = 0;
        int ca, cb, fb;
        for (int i = 0; i < N; i++) begin
            av[i] = int'(a[i*DW +: DW]);
            bv[i] = int'(b[i*DW +: DW]);
        end
        for (int i = 0; i < N - 1; i++) begin
            if (!oerr && (desc ? (bv[i] < bv[i+1]) : (bv[i] > bv[i+1]))) begin
                oerr = 1'b1;
                oi = i;
            end
        end
        for (int k = 0; k < N; k++) begin
            ca = 0;
            cb = 0;
            for (int j = 0; j < N; j++) begin
                if (av[j] == av[k]) ca++;
                if (bv[j] == av[k]) cb++;
            end
            if (!perr && ca != cb) begin
                perr = 1'b1;
                pi = k;
            end
        end
        fb = oerr ? oi : (perr ? pi : 0);
        return {~(oerr | perr), oerr, perr, IW'(fb)};
    endfunction

    function automatic logic [VW-1:0] sort_vec(input logic [VW-1:0] a);
        int v[N];
        int t;
        for (int i = 0; i < N; i++) v[i] = int'(a[i*DW +: DW]);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N - 1 - i; j++)
                if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
        return pk(v[0], v[1], v[2], v[3]);
    endfunction

    // ---------------- behavioural model / scoreboard ----------------
    logic [VDW-1:0] exp_q[$];
    int             m_phase = 0;       // 0 idle, k = k-th cycle after accept
    logic [VDW-1:0] m_hold  = '0;      // expected verdict outputs (pass starts 0)
    logic [15:0]    m_pass_cnt = '0;
    logic [15:0]    m_fail_cnt = '0;

    always @(negedge rst_n) begin
        exp_q.delete();
        m_phase    = 0;
        m_hold     = '0;
        m_pass_cnt = '0;
        m_fail_cnt = '0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (m_phase != 0) begin
                m_phase++;
                if (m_phase == N + 1) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL scoreboard_empty: got 0 entries expected 1 (cycle %0d)", cyc);
                    end else begin
                        m_hold = exp_q.pop_front();
                        if (m_hold[VDW-1]) begin
                            if (m_pass_cnt != 16'hFFFF) m_pass_cnt++;
                        end else begin
                            if (m_fail_cnt != 16'hFFFF) m_fail_cnt++;
                        end
                    end
                end else if (m_phase == N + 2) begin
                    m_phase = 0;
                end
            end else if (in_valid) begin
                exp_q.push_back(model_check(inp, outp, 1'b0));
                m_phase = 1;
            end
        end
    end

    // One compare process: every cycle, away from the active edge.
    int pulse_q[$];
    always @(negedge clk) begin
        chk("in_ready",      32'(in_ready),      32'(m_phase == 0));
        chk("res_valid",     32'(res_valid),     32'(m_phase == N + 1));
        chk("res_pass",      32'(res_pass),      32'(m_hold[VDW-1]));
        chk("res_order_err", 32'(res_order_err), 32'(m_hold[VDW-2]));
        chk("res_perm_err",  32'(res_perm_err),  32'(m_hold[VDW-3]));
        chk("res_first_bad", 32'(res_first_bad), 32'(m_hold[IW-1:0]));
`ifdef SORT_CHECK_STATS_EN
        chk("pass_cnt", 32'(pass_cnt), 32'(m_pass_cnt));
        chk("fail_cnt", 32'(fail_cnt), 32'(m_fail_cnt));
`endif
        if (res_valid === 1'b1) pulse_q.push_back(cyc);
    end

    // ---------------- driver tasks ----------------
    int last_acc = 0;

    task automatic wait_ready();
        int g = 0;
        while (in_ready !== 1'b1 && g < 50) begin
            @(posedge clk); #2;
            g++;
        end
        if (g >= 50) chk("ready_timeout", 32'(g), 32'd0);
    endtask

    task automatic send(input logic [VW-1:0] a, input logic [VW-1:0] b);
        @(posedge clk); #2;
        wait_ready();
        in_valid = 1'b1;
        inp      = a;
        outp     = b;
        @(posedge clk); #2;
        last_acc = cyc;
        in_valid = 1'b0;
        inp      = VW'($urandom);
        outp     = VW'($urandom);
    endtask

    task automatic wait_pulse(output int at);
        int g = 0;
        at = -1;
        while (g < 20) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin
                at = cyc;
                break;
            end
            g++;
        end
        if (at < 0) chk("pulse_timeout", 32'(g), 32'd0);
    endtask

    task automatic d_run(input string name, input logic [VW-1:0] a, input logic [VW-1:0] b,
                         input logic [VDW-1:0] exp);
        int g = 0;
        @(posedge clk); #2;
        while (d_in_ready !== 1'b1 && g < 50) begin @(posedge clk); #2; g++; end
        d_in_valid = 1'b1;
        d_inp      = a;
        d_outp     = b;
        @(posedge clk); #2;
        d_in_valid = 1'b0;
        g = 0;
        while (g < 20) begin
            @(negedge clk);
            if (d_res_valid === 1'b1) break;
            g++;
        end
        chk({name, "_valid"}, 32'(d_res_valid), 32'd1);
        chk({name, "_pass"},  32'(d_res_pass),      32'(exp[VDW-1]));
        chk({name, "_oerr"},  32'(d_res_order_err), 32'(exp[VDW-2]));
        chk({name, "_perr"},  32'(d_res_perm_err),  32'(exp[VDW-3]));
        chk({name, "_fb"},    32'(d_res_first_bad), 32'(exp[IW-1:0]));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t, t0, snap, g;
        logic [VW-1:0] a, b, s;
        logic [VW-1:0] pa[3];
        logic [VW-1:0] pb[3];

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_pass", 32'(res_pass), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Pin the model with hand-computed verdicts.
        chk("model_pass",  32'(model_check(pk(5,1,7,1), pk(1,1,5,7), 1'b0)), 32'b10000);
        chk("model_order", 32'(model_check(pk(5,1,7,1), pk(1,5,1,7), 1'b0)), 32'b01001);
        chk("model_perm",  32'(model_check(pk(5,1,7,1), pk(1,1,5,6), 1'b0)), 32'b00110);
        chk("model_dup",   32'(model_check(pk(3,3,3,3), pk(3,3,3,3), 1'b0)), 32'b10000);
        chk("model_desc",  32'(model_check(pk(0,6,2,4), pk(6,4,2,0), 1'b1)), 32'b10000);

        // Directed test-plan cases.
        send(pk(5,1,7,1), pk(1,1,5,7));
        wait_pulse(t);
        chk("latency", 32'(t - last_acc + 1), 32'd5);
        chk("d1_pass", 32'(res_pass), 32'd1);
        chk("d1_fb",   32'(res_first_bad), 32'd0);

        send(pk(5,1,7,1), pk(1,5,1,7));
        wait_pulse(t);
        chk("d2_oerr", 32'(res_order_err), 32'd1);
        chk("d2_perr", 32'(res_perm_err), 32'd0);
        chk("d2_fb",   32'(res_first_bad), 32'd1);
        chk("d2_pass", 32'(res_pass), 32'd0);

        send(pk(5,1,7,1), pk(1,1,5,6));
        wait_pulse(t);
        chk("d3_oerr", 32'(res_order_err), 32'd0);
        chk("d3_perr", 32'(res_perm_err), 32'd1);
        chk("d3_fb",   32'(res_first_bad), 32'd2);

        send(pk(3,3,3,3), pk(3,3,3,3));
        wait_pulse(t);
        chk("d4_pass", 32'(res_pass), 32'd1);

        d_run("desc_ok",  pk(0,6,2,4), pk(6,4,2,0), 5'b10000);
        d_run("desc_bad", pk(0,6,2,4), pk(6,2,4,0), 5'b01001);

        // in_valid held high across three distinct pairs.
        pa[0] = pk(2,0,1,3); pb[0] = pk(0,1,2,3);
        pa[1] = pk(7,7,0,4); pb[1] = pk(0,7,4,7);
        pa[2] = pk(6,5,4,3); pb[2] = pk(3,4,5,5);
        repeat (3) @(posedge clk);
        #2;
        wait_ready();
        pulse_q.delete();
        in_valid = 1'b1;
        inp = pa[0];
        outp = pb[0];
        t0 = 0;
        for (int p = 0; p < 3; p++) begin
            @(posedge clk); #2;
            if (p == 0) t0 = cyc;
            if (p < 2) begin
                inp  = pa[p+1];
                outp = pb[p+1];
                wait_ready();
            end else begin
                in_valid = 1'b0;
            end
        end
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("held_pulses", 32'(pulse_q.size()), 32'd3);
        if (pulse_q.size() == 3) begin
            chk("held_p0", 32'(pulse_q[0] - t0 + 1), 32'd5);
            chk("held_p1", 32'(pulse_q[1] - t0 + 1), 32'd11);
            chk("held_p2", 32'(pulse_q[2] - t0 + 1), 32'd17);
        end

        // Randomized pairs: correct, neighbour-swapped, one-element corrupted, or random.
        for (int it = 0; it < 60; it++) begin
            a = VW'($urandom);
            s = sort_vec(a);
            case ($urandom_range(0, 3))
                0: b = s;
                1: begin
                    g = $urandom_range(0, N - 2);
                    b = s;
                    b[g*DW +: DW]     = s[(g+1)*DW +: DW];
                    b[(g+1)*DW +: DW] = s[g*DW +: DW];
                end
                2: begin
                    g = $urandom_range(0, N - 1);
                    b = s;
                    b[g*DW +: DW] = DW'($urandom);
                end
                default: b = VW'($urandom);
            endcase
            send(a, b);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        repeat (N + 4) @(posedge clk);

        // Reset during the third SCAN cycle aborts the check.
        send(pk(5,1,7,1), pk(1,1,5,7));
        @(posedge clk);
        @(posedge clk); #2;
        snap = pulse_q.size();
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_pass",  32'(res_pass), 32'd0);
        chk("mid_rst_oerr",  32'(res_order_err), 32'd0);
        chk("mid_rst_perr",  32'(res_perm_err), 32'd0);
        chk("mid_rst_fb",    32'(res_first_bad), 32'd0);
`ifdef SORT_CHECK_STATS_EN
        chk("mid_rst_pcnt",  32'(pass_cnt), 32'd0);
        chk("mid_rst_fcnt",  32'(fail_cnt), 32'd0);
`endif
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (N + 4) @(posedge clk);
        @(negedge clk);
        chk("no_aborted_pulse", 32'(pulse_q.size()), 32'(snap));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sort_result_checker.md
# sort_result_checker

Self-checking receiver for `parallel_sorter` results. It accepts one (input vector, sorted output vector) pair per handshake and checks that the output is correctly ordered and is a permutation of the input. It then pulses a pass/fail verdict. It sits at the output end of the sorter test harness, opposite the counter stimulus generator, and runs on the same clock.

## Interface
Parameters:
- `DW`, default 3: element width in bits.
- `N`, default 4: number of elements; N ≥ 2.
- `DESCENDING`, default 0: 0 means slice 0 holds the smallest value; 1 means slice 0 holds the largest.

Ports. Element k of a packed vector is bits `[k*DW +: DW]`. `IW = max(1, clog2(N))`.
- `clk` input 1: clock; all state on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `inp`/`outp` pair is presented.
- `in_ready` output 1: checker can accept a pair.
- `inp` input DW*N: unsorted vector fed to the sorter.
- `outp` input DW*N: sorter result for `inp`.
- `res_valid` output 1: one-cycle verdict strobe.
- `res_pass` output 1: last verdict was pass.
- `res_order_err` output 1: last verdict had an ordering violation.
- `res_perm_err` output 1: last verdict had a multiset mismatch.
- `res_first_bad` output IW: element index of the first failure; 0 on pass.

## Operation
- FSM with states IDLE, SCAN and REPORT. Reset state is IDLE.
- `in_ready` is 1 only in IDLE.
- **IDLE**: on `in_valid && in_ready`:
  - register `inp` and `outp`;
  - compute the order check on the incoming `outp` combinationally and register it: violation at i when slice i > slice i+1 (ascending) or slice i < slice i+1 (descending); record the lowest violating i;
  - clear the perm flag, set idx = 0, go to SCAN.
- **SCAN**: one element per cycle, idx = 0..N-1.
  - key = captured `inp` slice idx.
  - Count matches of key in captured `inp` and in captured `outp`; count width `clog2(N+1)`.
  - On the first unequal count, set the perm flag and record idx.
  - After idx = N-1, go to REPORT.
  - idx is not compared against `outp`-only values. A value present only in `outp` implies some `inp` value is missing, so scanning `inp` keys is sufficient.
- **REPORT**:
  - `res_valid` = 1 for exactly this cycle.
  - `res_order_err` and `res_perm_err` load their flags.
  - `res_pass` = NOR of both flags.
  - `res_first_bad` = order index if there is an order error, else perm index if there is a perm error, else 0.
  - Go to IDLE.
- Verdict outputs hold their value until the next REPORT.
- Duplicate elements are legal. Equal neighbours are not an order violation.
- All comparisons are unsigned.

## Timing
- Reset (asynchronous assert): state IDLE, `in_ready` = 1, `res_valid` = 0, `res_pass` = 0, both error flags 0, `res_first_bad` = 0, idx = 0.
- Accept at edge 0 → SCAN during cycles 1..N → `res_valid` high in cycle N+1 → IDLE in cycle N+2.
- Throughput is one pair per N+2 cycles. For N = 4, the verdict is in cycle 5 and the next accept is at cycle 6.
- `inp` and `outp` are sampled only on the accept edge. Later changes are ignored.
- `in_valid` held high continuously: a new pair is accepted on each IDLE cycle; no pair is lost or double-counted.
- Reset mid-SCAN or mid-REPORT aborts the check. No `res_valid` pulse is produced for the aborted pair.

## Configuration
- `SORT_CHECK_STATS_EN`:
  - When defined, adds output ports `pass_cnt` [15:0] and `fail_cnt` [15:0]. Each increments on its REPORT outcome and saturates at 16'hFFFF. Both reset to 0.
  - When undefined, the ports and counters are absent and the rest of the behaviour is identical.

## Structure
- Shared package `sorter_pkg`:
  - `clog2` function;
  - IW and count-width localparam derivations, reused by `parallel_sorter`;
  - FSM state enum `chk_state_t` (IDLE, SCAN, REPORT).
- Sub-module `elem_match_count` (parameters DW, N):
  - inputs: key and packed vector; output: number of slices equal to key;
  - purely combinational; instantiated twice (input side and output side).

## Test plan
Defaults DW = 3, N = 4, ascending. Slices listed 0..3.
- inp 5,1,7,1 and outp 1,1,5,7 → `res_valid` in cycle 5, pass = 1, both errors 0, first_bad 0.
- inp 5,1,7,1 and outp 1,5,1,7 → order_err = 1, perm_err = 0, first_bad 1, pass = 0.
- inp 5,1,7,1 and outp 1,1,5,6 → order_err = 0, perm_err = 1, first_bad 2, pass = 0.
- inp 3,3,3,3 and outp 3,3,3,3 → pass. Repeat with `DESCENDING` = 1, inp 0,6,2,4 and outp 6,4,2,0 → pass.
- `in_valid` held high with 3 distinct pairs → exactly 3 `res_valid` pulses, at cycles 5, 11 and 17.
- Assert `rst_n` low in cycle 3 of SCAN → no pulse; all outputs at reset values. With `SORT_CHECK_STATS_EN`, counters read 0.
